// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Holds the operation encodings, the FSM state enum and the datapath
// width/iteration constants. Also a pair of helpers that decode the
// operation select into "signed" and "divide" flags.
package mdu_pkg;

  localparam int WIDTH = 32;
  localparam int ITER  = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // MULT and DIV (op[0]==0) treat operands as two's complement.
  function automatic logic is_signed_op(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic is_div_op(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Execute-stage request/response bundle of the multiply/divide unit.
//
// Handshake: the master raises start for one cycle with op/a/b valid;
// the unit samples it on the rising edge only while busy=0 (start while
// busy=1 is ignored). busy stays high for the whole operation and done
// pulses for one cycle when the new HI/LO values are visible on hi/lo.
// hi_we/lo_we with wdata perform MTHI/MTLO and are honoured only when
// busy=0 and start=0.
//
// Signals: start, op[1:0], a, b, hi_we, lo_we, wdata (master -> unit);
//          busy, done, hi, lo (unit -> master).
interface mult_div_unit_if;
  import mdu_pkg::*;

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/mdu_sign_fix.sv
// Combinational conditional two's complement negate.
// Used both to turn signed operands into magnitudes and to apply the
// final sign to products, quotients and remainders.
// Ports: val (W bits in), neg (negate when 1), res (W bits out).
module mdu_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit (MULT, MULTU, DIV, DIVU) that owns the
// architectural HI/LO registers. One shift/add or shift/subtract step per
// cycle over a 64-bit accumulator, followed by a sign-correction cycle.
// Only WIDTH=32 with ITER=WIDTH is supported.
// Ports: clk, reset (sync, active high), bus (slave side of
//        mult_div_unit_if), dbg_state (current FSM state).
module mult_div_unit #(
  parameter int          WIDTH   = 32,
  parameter int          ITER    = 32,
  parameter logic [31:0] DIV0_LO = 32'hFFFF_FFFF
) (
  input  logic             clk,
  input  logic             reset,
  mult_div_unit_if.slave   bus,
  output mdu_pkg::state_t  dbg_state
);
  import mdu_pkg::*;

  localparam int CW = $clog2(ITER);

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic               is_div_q;
  logic               neg_res_q;   // quotient/product sign differs from magnitude
  logic               neg_rem_q;   // remainder follows dividend sign
  logic               div0_q;
  logic [WIDTH-1:0]   a_raw_q;     // kept for HI on divide-by-zero
  logic [WIDTH-1:0]   opb_q;       // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_q;       // {acc, multiplier} or {remainder, quotient}
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;

  // Operand magnitudes at accept time.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign a_neg = is_signed_op(bus.op) & bus.a[WIDTH-1];
  assign b_neg = is_signed_op(bus.op) & bus.b[WIDTH-1];

  mdu_sign_fix #(.W(WIDTH)) u_abs_a (.val(bus.a), .neg(a_neg), .res(a_mag));
  mdu_sign_fix #(.W(WIDTH)) u_abs_b (.val(bus.b), .neg(b_neg), .res(b_mag));

  // Result sign correction.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  mdu_sign_fix #(.W(2*WIDTH)) u_neg_prod (.val(acc_q), .neg(neg_res_q), .res(prod_fix));
  mdu_sign_fix #(.W(WIDTH)) u_neg_quo (.val(acc_q[WIDTH-1:0]), .neg(neg_res_q), .res(quo_fix));
  mdu_sign_fix #(.W(WIDTH)) u_neg_rem (.val(acc_q[2*WIDTH-1:WIDTH]), .neg(neg_rem_q), .res(rem_fix));

  // Multiply step: add multiplicand when the multiplier LSB is set, then
  // shift the whole {acc, multiplier} pair right with the carry.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide step: shift {rem, quo} left one bit and subtract the divisor if
  // it fits. The trial value is 33 bits; after a successful subtract the
  // difference is below the divisor, so its low 32 bits are exact.
  logic [WIDTH:0]     div_trial;
  logic [WIDTH-1:0]   div_diff;
  logic               div_fits;
  logic [2*WIDTH-1:0] div_next;

  assign div_trial = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_trial[WIDTH-1:0] - opb_q;
  assign div_fits  = div_trial >= {1'b0, opb_q};
  assign div_next  = div_fits ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                              : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

  logic last_iter;
  assign last_iter = (cnt_q == CW'(ITER - 1));

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_iter) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      a_raw_q   <= '0;
      opb_q     <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            is_div_q  <= is_div_op(bus.op);
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            div0_q    <= is_div_op(bus.op) && (bus.b == '0);
            a_raw_q   <= bus.a;
            cnt_q     <= '0;
            // Divide iterates on the dividend; multiply shifts the multiplier.
            if (is_div_op(bus.op)) begin
              acc_q <= {{WIDTH{1'b0}}, a_mag};
              opb_q <= b_mag;
            end else begin
              acc_q <= {{WIDTH{1'b0}}, b_mag};
              opb_q <= a_mag;
            end
          end else begin
            if (bus.hi_we) hi_q <= bus.wdata;
            if (bus.lo_we) lo_q <= bus.wdata;
          end
        end
        RUN: begin
          acc_q <= is_div_q ? div_next : mul_next;
          cnt_q <= cnt_q + CW'(1);
        end
        FIX: begin
          done_q <= 1'b1;
          if (div0_q) begin
            hi_q <= a_raw_q;
            lo_q <= DIV0_LO[WIDTH-1:0];
          end else if (is_div_q) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed operations with
// hand-computed HI/LO, plus a cycle-level model (plain arithmetic on
// longints, a countdown for busy, an expected-result queue) compared
// against busy/done/hi/lo every cycle.
module tb_mult_div_unit;
  import mdu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mult_div_unit_if bus();
  state_t dbg_state;

  mult_div_unit #(
    .WIDTH(32),
    .ITER(32),
    .DIV0_LO(32'hFFFF_FFFF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [63:0] model_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      OP_MULT:  begin q = sa * sb; p = q; return p; end
      OP_MULTU: begin p = ua * ub; return p; end
      OP_DIV: begin
        if (b == 32'b0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'b0) return {a, 32'hFFFF_FFFF};
        p = {ua % ub, 32'b0} | (ua / ub);
        return p;
      end
    endcase
  endfunction

  logic [63:0] exp_q[$];
  int          m_left = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic        m_done = 1'b0;
  logic        m_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_left  = 0;
      m_hi    = '0;
      m_lo    = '0;
      m_done  = 1'b0;
      m_valid = 1'b1;
      exp_q.delete();
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          if (exp_q.size() > 0) {m_hi, m_lo} = exp_q.pop_front();
          m_done = 1'b1;
        end
      end else if (bus.start) begin
        exp_q.push_back(model_result(bus.op, bus.a, bus.b));
        m_left = 33;
      end else begin
        if (bus.hi_we) m_hi = bus.wdata;
        if (bus.lo_we) m_lo = bus.wdata;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      check("busy", 32'(bus.busy), 32'(m_left > 0));
      check("done", 32'(bus.done), 32'(m_done));
      check("hi", bus.hi, m_hi);
      check("lo", bus.lo, m_lo);
      check("state_idle", 32'(dbg_state == IDLE), 32'(m_left == 0));
    end
  end

  // ---------------- driver tasks ----------------
  // Call at a negedge; returns at the negedge after the accepting edge.
  task automatic drive_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  task automatic wait_done(output int waited);
    waited = 0;
    while (!bus.done && waited < 100) begin
      @(negedge clk);
      waited++;
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int w;
    @(negedge clk);
    drive_start(op, a, b);
    wait_done(w);
    check({name, "_latency"}, 32'(w), 32'd33);
    check({name, "_hi"}, bus.hi, exp_hi);
    check({name, "_lo"}, bus.lo, exp_lo);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  vec_t vecs[6] = '{
    '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD},
    '{OP_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003},
    '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000},
    '{OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF},
    '{OP_MULT,  32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001},
    '{OP_DIVU,  32'h0000_0005, 32'h0000_000A, 32'h0000_0005, 32'h0000_0000}
  };

  // ---------------- main sequence ----------------
  initial begin
    int w;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    reset     = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_hi", bus.hi, 32'h0);
    check("reset_lo", bus.lo, 32'h0);
    check("reset_busy", 32'(bus.busy), 32'h0);
    check("reset_done", 32'(bus.done), 32'h0);
    reset = 1'b0;

    run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);

    // Back-to-back: second start driven in the done cycle.
    @(negedge clk);
    drive_start(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(w);
    check("multu_max_latency", 32'(w), 32'd33);
    check("multu_max_hi", bus.hi, 32'hFFFF_FFFE);
    check("multu_max_lo", bus.lo, 32'h0000_0001);
    drive_start(OP_DIVU, 32'd1000, 32'd7);
    wait_done(w);
    check("b2b_latency", 32'(w), 32'd33);
    check("b2b_hi", bus.hi, 32'd6);
    check("b2b_lo", bus.lo, 32'd142);

    run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run_op("divu_zero", OP_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
    run_op("div_zero_neg", OP_DIV, 32'hFFFF_FF9C, 32'd0, 32'hFFFF_FF9C, 32'hFFFF_FFFF);

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

    // MTLO then MTHI while idle.
    @(negedge clk);
    bus.lo_we = 1'b1;
    bus.wdata = 32'h0000_1234;
    @(negedge clk);
    bus.lo_we = 1'b0;
    check("mtlo", bus.lo, 32'h0000_1234);
    bus.hi_we = 1'b1;
    bus.wdata = 32'h0000_ABCD;
    @(negedge clk);
    bus.hi_we = 1'b0;
    check("mthi", bus.hi, 32'h0000_ABCD);

    // MTHI and start during busy are both ignored.
    drive_start(OP_MULTU, 32'd3, 32'd4);
    repeat (5) @(negedge clk);
    bus.hi_we = 1'b1;
    bus.wdata = 32'hDEAD_BEEF;
    bus.start = 1'b1;
    bus.op    = OP_DIVU;
    bus.a     = 32'd9;
    bus.b     = 32'd0;
    @(negedge clk);
    bus.hi_we = 1'b0;
    bus.start = 1'b0;
    check("busy_mthi_hi", bus.hi, 32'h0000_ABCD);
    check("busy_mthi_lo", bus.lo, 32'h0000_1234);
    wait_done(w);
    check("busy_ign_hi", bus.hi, 32'd0);
    check("busy_ign_lo", bus.lo, 32'd12);
    repeat (2) @(negedge clk);
    check("busy_ign_no_restart", 32'(bus.busy), 32'h0);

    // start and lo_we together: the write is dropped.
    bus.lo_we = 1'b1;
    bus.wdata = 32'h0000_5555;
    drive_start(OP_MULT, 32'd2, 32'd3);
    bus.lo_we = 1'b0;
    check("start_wins_lo", bus.lo, 32'd12);
    wait_done(w);
    check("start_wins_res_hi", bus.hi, 32'd0);
    check("start_wins_res_lo", bus.lo, 32'd6);

    // Both write enables.
    @(negedge clk);
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'h0000_0077;
    @(negedge clk);
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    check("mt_both_hi", bus.hi, 32'h77);
    check("mt_both_lo", bus.lo, 32'h77);

    // Reset in the middle of a divide.
    drive_start(OP_DIVU, 32'd50, 32'd3);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'h0);
    check("abort_hi", bus.hi, 32'h0);
    check("abort_lo", bus.lo, 32'h0);
    check("abort_done", 32'(bus.done), 32'h0);
    repeat (40) @(negedge clk);
    run_op("after_abort", OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
